network_tx_queued: RTL and testbench

//  Parametrised successor to the vanilla core's outgoing-request stage.
//  - Buffers already-built remote request packets in an els_p-deep FIFO.
//  - Drives the manycore network in either credit or ready/valid mode.
//  - Tracks outstanding requests against a cap and exposes an idle/fence flag.
//  - Drops illegal-EVA requests at the head and captures the first one in a sticky error register.

---
 rtl/network_tx_queued.sv | 115 +++++++++++
 tb/tb_network_tx_queued.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_tx_queued.sv
// Outgoing remote-request stage: FIFO of prebuilt packets feeding the network link
// in credit or ready/valid mode, with outstanding tracking and illegal-EVA capture.
module network_tx_queued #(
    parameter int packet_width_p = 100,
    parameter int addr_width_p   = 28,
    parameter int els_p          = 4,
    parameter bit use_credits_p  = 1'b1,
    parameter int net_credits_p  = 4,
    parameter int max_out_p      = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             req_v_i,
    input  logic [packet_width_p-1:0]        req_packet_i,
    input  logic                             req_illegal_i,
    input  logic [addr_width_p-1:0]          req_addr_i,
    output logic                             req_credit_o,
    output logic [packet_width_p-1:0]        out_packet_o,
    output logic                             out_v_o,
    input  logic                             out_credit_or_ready_i,
    input  logic                             returned_v_i,
    output logic [$clog2(max_out_p+1)-1:0]   outstanding_o,
    output logic                             idle_o,
    output logic                             err_v_o,
    output logic [addr_width_p-1:0]          err_addr_o,
    input  logic                             err_clear_i
);
    localparam int ptr_w  = $clog2(els_p);
    localparam int cnt_w  = $clog2(els_p + 1);
    localparam int out_w  = $clog2(max_out_p + 1);
    localparam int cred_w = $clog2(net_credits_p + 1);

    typedef struct packed {
        logic [packet_width_p-1:0] packet;
        logic                      illegal;
        logic [addr_width_p-1:0]   addr;
    } entry_t;

    entry_t            mem [els_p];
    entry_t            head;
    logic [ptr_w-1:0]  wr_ptr, rd_ptr;
    logic [cnt_w-1:0]  count;
    logic [cred_w-1:0] net_credit_cnt;
    logic              head_v, full, link_ok, send, drop, deq, enq;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head    = mem[rd_ptr];
    assign head_v  = (count != '0);
    assign full    = (count == cnt_w'(els_p));
    assign link_ok = use_credits_p ? (net_credit_cnt != '0) : out_credit_or_ready_i;
    assign send    = head_v & ~head.illegal & (outstanding_o < out_w'(max_out_p)) & link_ok;
    assign drop    = head_v & head.illegal;
    assign deq     = send | drop;
    // A dequeue in the same cycle frees the slot, so a write while full is accepted.
    assign enq     = req_v_i & (~full | deq);

    assign out_v_o      = send;
    assign out_packet_o = head.packet;
    assign req_credit_o = deq;
    assign idle_o       = ~head_v & (outstanding_o == '0);

    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr] <= '{packet: req_packet_i, illegal: req_illegal_i, addr: req_addr_i};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            outstanding_o  <= '0;
            net_credit_cnt <= cred_w'(net_credits_p);
            err_v_o        <= 1'b0;
            err_addr_o     <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;

            if (send && !returned_v_i)
                outstanding_o <= outstanding_o + 1'b1;
            else if (!send && returned_v_i && outstanding_o != '0)
                outstanding_o <= outstanding_o - 1'b1;

            if (use_credits_p) begin
                if (send && !out_credit_or_ready_i)
                    net_credit_cnt <= net_credit_cnt - 1'b1;
                else if (!send && out_credit_or_ready_i && net_credit_cnt != cred_w'(net_credits_p))
                    net_credit_cnt <= net_credit_cnt + 1'b1;
            end

            if (err_clear_i) begin
                err_v_o    <= 1'b0;
                err_addr_o <= '0;
            end else if (drop && !err_v_o) begin
                err_v_o    <= 1'b1;
                err_addr_o <= head.addr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(req_v_i && full && !deq)) else $error("enqueue while FIFO full");
            assert (!(returned_v_i && !send && outstanding_o == '0)) else $error("return with none outstanding");
            assert (!(use_credits_p && out_credit_or_ready_i && !send &&
                      net_credit_cnt == cred_w'(net_credits_p))) else $error("network credit overflow");
        end
    end
endmodule

// File: tb/tb_network_tx_queued.sv
// Scoreboarded bench: four configurations of network_tx_queued exercised in turn.
module tb_network_tx_queued;
    localparam int PW = 16;
    localparam int AW = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [3:0]          req_v, req_ill, ocr, ret, err_clr;
    logic [3:0][PW-1:0]  req_pkt;
    logic [3:0][AW-1:0]  req_addr;
    logic [3:0]          req_credit, out_v, idle, err_v;
    logic [3:0][PW-1:0]  out_pkt;
    logic [3:0][AW-1:0]  err_addr;
    logic [5:0]          outst0, outst1, outst3;
    logic [1:0]          outst2;

    int passes = 0;
    int total  = 0;
    int rc_cnt [4];
    logic [PW-1:0] exp_q [$];

    network_tx_queued #(.packet_width_p(PW), .addr_width_p(AW)) u_d0 (
        .clk_i(clk), .reset_n_i(rst_n), .req_v_i(req_v[0]), .req_packet_i(req_pkt[0]),
        .req_illegal_i(req_ill[0]), .req_addr_i(req_addr[0]), .req_credit_o(req_credit[0]),
        .out_packet_o(out_pkt[0]), .out_v_o(out_v[0]), .out_credit_or_ready_i(ocr[0]),
        .returned_v_i(ret[0]), .outstanding_o(outst0), .idle_o(idle[0]), .err_v_o(err_v[0]),
        .err_addr_o(err_addr[0]), .err_clear_i(err_clr[0]));

    network_tx_queued #(.packet_width_p(PW), .addr_width_p(AW), .net_credits_p(2)) u_d1 (
        .clk_i(clk), .reset_n_i(rst_n), .req_v_i(req_v[1]), .req_packet_i(req_pkt[1]),
        .req_illegal_i(req_ill[1]), .req_addr_i(req_addr[1]), .req_credit_o(req_credit[1]),
        .out_packet_o(out_pkt[1]), .out_v_o(out_v[1]), .out_credit_or_ready_i(ocr[1]),
        .returned_v_i(ret[1]), .outstanding_o(outst1), .idle_o(idle[1]), .err_v_o(err_v[1]),
        .err_addr_o(err_addr[1]), .err_clear_i(err_clr[1]));

    network_tx_queued #(.packet_width_p(PW), .addr_width_p(AW), .max_out_p(2)) u_d2 (
        .clk_i(clk), .reset_n_i(rst_n), .req_v_i(req_v[2]), .req_packet_i(req_pkt[2]),
        .req_illegal_i(req_ill[2]), .req_addr_i(req_addr[2]), .req_credit_o(req_credit[2]),
        .out_packet_o(out_pkt[2]), .out_v_o(out_v[2]), .out_credit_or_ready_i(ocr[2]),
        .returned_v_i(ret[2]), .outstanding_o(outst2), .idle_o(idle[2]), .err_v_o(err_v[2]),
        .err_addr_o(err_addr[2]), .err_clear_i(err_clr[2]));

    network_tx_queued #(.packet_width_p(PW), .addr_width_p(AW), .use_credits_p(1'b0)) u_d3 (
        .clk_i(clk), .reset_n_i(rst_n), .req_v_i(req_v[3]), .req_packet_i(req_pkt[3]),
        .req_illegal_i(req_ill[3]), .req_addr_i(req_addr[3]), .req_credit_o(req_credit[3]),
        .out_packet_o(out_pkt[3]), .out_v_o(out_v[3]), .out_credit_or_ready_i(ocr[3]),
        .returned_v_i(ret[3]), .outstanding_o(outst3), .idle_o(idle[3]), .err_v_o(err_v[3]),
        .err_addr_o(err_addr[3]), .err_clear_i(err_clr[3]));

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every send must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 4; d++) begin
                if (out_v[d]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected send dut%0d: got 0x%0h, expected no send", d, out_pkt[d]);
                    end else begin
                        check($sformatf("packet dut%0d", d), out_pkt[d], exp_q.pop_front());
                    end
                end
                if (req_credit[d]) rc_cnt[d]++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        req_v = '0; req_ill = '0; ocr = '0; ret = '0; err_clr = '0;
        req_pkt = '0; req_addr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        exp_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic enq(input int d, input logic [PW-1:0] p, input logic ill, input logic [AW-1:0] a);
        req_v[d] = 1'b1; req_pkt[d] = p; req_ill[d] = ill; req_addr[d] = a;
        if (!ill) exp_q.push_back(p);
    endtask

    function automatic int outst(input int d);
        case (d)
            0: return int'(outst0);
            1: return int'(outst1);
            2: return int'(outst2);
            default: return int'(outst3);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int d = 0; d < 4; d++) rc_cnt[d] = 0;

        // Reset state, then three legal requests in credit mode
        do_reset();
        @(negedge clk);
        check("rst out_v", out_v[0], 0);
        check("rst req_credit", req_credit[0], 0);
        check("rst idle", idle[0], 1);
        check("rst err_v", err_v[0], 0);
        check("rst err_addr", err_addr[0], 0);
        check("rst outstanding", outst(0), 0);
        cyc();
        base = rc_cnt[0];
        for (int i = 0; i < 3; i++) begin
            enq(0, PW'(16'hA000 + i), 1'b0, '0);
            @(negedge clk);
            check($sformatf("t1 out_v c%0d", i), out_v[0], (i > 0));
            cyc();
        end
        req_v[0] = 1'b0;
        @(negedge clk); check("t1 out_v c3", out_v[0], 1); cyc();
        @(negedge clk);
        check("t1 out_v c4", out_v[0], 0);
        check("t1 outstanding", outst(0), 3);
        check("t1 idle", idle[0], 0);
        check("t1 req_credit pulses", rc_cnt[0] - base, 3);
        check("t1 queue drained", exp_q.size(), 0);

        // Two network credits, four requests
        do_reset(); cyc();
        for (int i = 0; i < 4; i++) begin
            enq(1, PW'(16'hB000 + i), 1'b0, '0);
            @(negedge clk);
            check($sformatf("t2 out_v c%0d", i), out_v[1], (i == 1 || i == 2));
            cyc();
        end
        req_v[1] = 1'b0;
        @(negedge clk); check("t2 stalled", out_v[1], 0); check("t2 outstanding", outst(1), 2); cyc();
        ocr[1] = 1'b1;
        @(negedge clk); check("t2 out_v at credit", out_v[1], 0); cyc();
        ocr[1] = 1'b0;
        @(negedge clk); check("t2 3rd sent", out_v[1], 1); cyc();
        @(negedge clk); check("t2 stalled again", out_v[1], 0); check("t2 outstanding 3", outst(1), 3); cyc();
        ocr[1] = 1'b1; cyc(); ocr[1] = 1'b0;
        @(negedge clk); check("t2 4th sent", out_v[1], 1); cyc();
        @(negedge clk); check("t2 outstanding 4", outst(1), 4); check("t2 queue drained", exp_q.size(), 0);

        // Outstanding cap of two
        do_reset(); cyc();
        for (int i = 0; i < 3; i++) begin
            enq(2, PW'(16'hC000 + i), 1'b0, '0);
            @(negedge clk);
            check($sformatf("t3 out_v c%0d", i), out_v[2], (i > 0));
            cyc();
        end
        req_v[2] = 1'b0;
        @(negedge clk); check("t3 held", out_v[2], 0); check("t3 outstanding cap", outst(2), 2); cyc();
        @(negedge clk); check("t3 still held", out_v[2], 0); cyc();
        ret[2] = 1'b1;
        @(negedge clk); check("t3 held at return", out_v[2], 0); cyc();
        ret[2] = 1'b0;
        @(negedge clk); check("t3 3rd sent", out_v[2], 1); cyc();
        @(negedge clk); check("t3 outstanding back at 2", outst(2), 2); cyc();
        enq(2, 16'hC003, 1'b0, '0); ret[2] = 1'b1;
        @(negedge clk); cyc();
        req_v[2] = 1'b0;
        @(negedge clk); check("t3 send with return", out_v[2], 1); cyc();
        ret[2] = 1'b0;
        @(negedge clk); check("t3 send+return unchanged", outst(2), 1); check("t3 queue drained", exp_q.size(), 0);

        // Illegal EVA capture
        do_reset(); cyc();
        enq(0, 16'hDEAD, 1'b1, 28'h0ABCDEF);
        @(negedge clk); check("t4 out_v c0", out_v[0], 0); cyc();
        enq(0, 16'hD001, 1'b0, '0);
        @(negedge clk);
        check("t4 illegal not sent", out_v[0], 0);
        check("t4 drop credit", req_credit[0], 1);
        check("t4 err_v not yet", err_v[0], 0);
        cyc();
        req_v[0] = 1'b0;
        @(negedge clk);
        check("t4 err_v", err_v[0], 1);
        check("t4 err_addr", err_addr[0], 28'h0ABCDEF);
        check("t4 legal sent", out_v[0], 1);
        cyc();
        enq(0, 16'hBEEF, 1'b1, 28'h1234567);
        @(negedge clk); cyc();
        req_v[0] = 1'b0;
        @(negedge clk); check("t4 2nd illegal dropped", req_credit[0], 1); check("t4 2nd not sent", out_v[0], 0); cyc();
        @(negedge clk); check("t4 err_addr kept", err_addr[0], 28'h0ABCDEF); check("t4 err_v kept", err_v[0], 1); cyc();
        err_clr[0] = 1'b1;
        @(negedge clk); cyc();
        err_clr[0] = 1'b0;
        @(negedge clk); check("t4 err_v cleared", err_v[0], 0); check("t4 err_addr cleared", err_addr[0], 0);
        check("t4 queue drained", exp_q.size(), 0);

        // Ready/valid mode: ready low then drain
        do_reset(); cyc();
        for (int i = 0; i < 4; i++) begin
            enq(3, PW'(16'hE000 + i), 1'b0, '0);
            @(negedge clk); check($sformatf("t5 enq c%0d", i), out_v[3], 0); cyc();
        end
        req_v[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); check($sformatf("t5 ready low c%0d", k), out_v[3], 0); cyc();
        end
        @(negedge clk); check("t5 not idle", idle[3], 0); cyc();
        base = rc_cnt[3];
        ocr[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); check($sformatf("t5 drain c%0d", k), out_v[3], 1); cyc();
        end
        @(negedge clk);
        check("t5 empty", out_v[3], 0);
        check("t5 outstanding", outst(3), 4);
        check("t5 req_credit pulses", rc_cnt[3] - base, 4);
        check("t5 queue drained", exp_q.size(), 0);
        ocr[3] = 1'b0;
        cyc();

        // Reset with entries queued and one outstanding
        do_reset(); cyc();
        for (int i = 0; i < 4; i++) begin
            enq(1, PW'(16'hF000 + i), 1'b0, '0);
            @(negedge clk); cyc();
        end
        req_v[1] = 1'b0; ret[1] = 1'b1;
        @(negedge clk); cyc();
        ret[1] = 1'b0;
        @(negedge clk); check("t6 outstanding pre", outst(1), 1); check("t6 busy pre", idle[1], 0); cyc();
        rst_n = 1'b0; exp_q.delete();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6 idle", idle[1], 1);
        check("t6 outstanding", outst(1), 0);
        check("t6 out_v", out_v[1], 0);
        check("t6 err_v", err_v[1], 0);
        cyc();
        enq(1, 16'hF100, 1'b0, '0);
        @(negedge clk); cyc();
        req_v[1] = 1'b0;
        @(negedge clk); check("t6 fresh send", out_v[1], 1); cyc();
        @(negedge clk); check("t6 queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
